bcd_divider: RTL



---
 rtl/bcd_divider.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bcd_divider.sv
// rtl/bcd_divider.sv - sequential BCD divider: operand check, restoring divide, double-dabble
// Optional macro BCD_DIV_FASTOUT_EN swaps the DD sequence for a combinational binary-to-BCD stage.
module bcd_divider (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [0:7] bcd_dividend,
    input  logic [0:3] bcd_divisor,
    output logic       busy,
    output logic       done,
    output logic [0:7] bcd_quotient,
    output logic [0:3] bcd_remainder,
    output logic [0:1] err,
    output logic       div_zero
);
    typedef enum logic [2:0] {IDLE, CHECK, DIV, DD, DONE} state_t;
    state_t state, state_next;

    logic [7:0] dvd_op;
    logic [3:0] dsr_op;
    logic [6:0] work;     // binary dividend; quotient bits shift in at the LSB
    logic [3:0] rem;
    logic [2:0] cnt;

    logic       dvd_bad, dsr_bad;
    logic [6:0] bin_dvd;
    logic [4:0] trial, diff;
    logic       fits;
    logic [3:0] div_rem;
    logic [6:0] div_work;

    assign dvd_bad  = (dvd_op[7:4] > 4'd9) || (dvd_op[3:0] > 4'd9);
    assign dsr_bad  = dsr_op > 4'd9;
    assign bin_dvd  = 7'(dvd_op[7:4]) * 7'd10 + 7'(dvd_op[3:0]);

    assign trial    = {rem, work[6]};
    assign fits     = trial >= {1'b0, dsr_op};
    assign diff     = trial - {1'b0, dsr_op};
    assign div_rem  = fits ? diff[3:0] : trial[3:0];
    assign div_work = {work[5:0], fits};

`ifdef BCD_DIV_FASTOUT_EN
    function automatic logic [7:0] to_bcd(input logic [6:0] bin);
        logic [14:0] sh;
        sh = {8'd0, bin};
        for (int i = 0; i < 7; i++) begin
            if (sh[10:7] >= 4'd5)  sh[10:7]  = sh[10:7] + 4'd3;
            if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
            sh = sh << 1;
        end
        return sh[14:7];
    endfunction
`else
    logic [7:0] bcd_acc;
    logic [7:0] adj;
    logic [7:0] dd_acc;
    logic [6:0] dd_work;

    assign adj[3:0] = (bcd_acc[3:0] >= 4'd5) ? bcd_acc[3:0] + 4'd3 : bcd_acc[3:0];
    assign adj[7:4] = (bcd_acc[7:4] >= 4'd5) ? bcd_acc[7:4] + 4'd3 : bcd_acc[7:4];
    assign dd_acc   = {adj[6:0], work[6]};
    assign dd_work  = {work[5:0], 1'b0};
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = CHECK;
            CHECK: begin
                if (dvd_bad || dsr_bad || dsr_op == 4'd0) state_next = DONE;
                else                                      state_next = DIV;
            end
`ifdef BCD_DIV_FASTOUT_EN
            DIV:   if (cnt == 3'd6) state_next = DONE;
`else
            DIV:   if (cnt == 3'd6) state_next = DD;
            DD:    if (cnt == 3'd6) state_next = DONE;
`endif
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CHECK) || (state == DIV) || (state == DD);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            dvd_op        <= 8'd0;
            dsr_op        <= 4'd0;
            work          <= 7'd0;
            rem           <= 4'd0;
            cnt           <= 3'd0;
            bcd_quotient  <= 8'd0;
            bcd_remainder <= 4'd0;
            err           <= 2'd0;
            div_zero      <= 1'b0;
`ifndef BCD_DIV_FASTOUT_EN
            bcd_acc       <= 8'd0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_op <= bcd_dividend;
                        dsr_op <= bcd_divisor;
                    end
                end
                CHECK: begin
                    work <= bin_dvd;
                    rem  <= 4'd0;
                    cnt  <= 3'd0;
                    if (dvd_bad || dsr_bad) begin
                        bcd_quotient  <= {(dvd_bad ? 4'hF : 4'h0), (dsr_bad ? 4'hF : 4'h0)};
                        bcd_remainder <= 4'hF;
                        err           <= {dvd_bad, dsr_bad};
                        div_zero      <= 1'b0;
                    end else if (dsr_op == 4'd0) begin
                        bcd_quotient  <= 8'hEE;
                        bcd_remainder <= 4'hE;
                        err           <= 2'b00;
                        div_zero      <= 1'b1;
                    end
                end
                DIV: begin
                    work <= div_work;
                    rem  <= div_rem;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd6) begin
`ifdef BCD_DIV_FASTOUT_EN
                        bcd_quotient  <= to_bcd(div_work);
                        bcd_remainder <= div_rem;
                        err           <= 2'b00;
                        div_zero      <= 1'b0;
`else
                        cnt     <= 3'd0;
                        bcd_acc <= 8'd0;
`endif
                    end
                end
`ifndef BCD_DIV_FASTOUT_EN
                DD: begin
                    bcd_acc <= dd_acc;
                    work    <= dd_work;
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd6) begin
                        bcd_quotient  <= dd_acc;
                        bcd_remainder <= rem;
                        err           <= 2'b00;
                        div_zero      <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
